// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences single-word core requests into SRAM bus cycles and owns the data bus.
// Optional feature macro: SRAM_CTRL_VERIFY_EN adds a readback-and-compare after every write.

module sram_ctrl #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_WR_REC
`ifdef SRAM_CTRL_VERIFY_EN
    , S_VFY
`endif
  } state_e;

  // Capture happens on the edge that ends the (RD_WAIT+2)-cycle read window.
  localparam logic [3:0] LastCnt = 4'(RD_WAIT + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
`ifdef SRAM_CTRL_VERIFY_EN
  logic                err_q, err_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef SRAM_CTRL_VERIFY_EN
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
    err_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = req_we ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == LastCnt) begin
          rdata_d     = mem_data;
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR: begin
        state_d = S_WR_REC;
      end
      S_WR_REC: begin
        // Bus is released here so a following mem_oe never overlaps our drive.
`ifdef SRAM_CTRL_VERIFY_EN
        cnt_d   = '0;
        state_d = S_VFY;
`else
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
`endif
      end
`ifdef SRAM_CTRL_VERIFY_EN
      S_VFY: begin
        if (cnt_q == LastCnt) begin
          rdata_d     = mem_data;
          err_d       = (mem_data != wdata_q);
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign mem_we    = (state_q == S_WR);
`ifdef SRAM_CTRL_VERIFY_EN
  assign mem_oe    = (state_q == S_RD) || (state_q == S_VFY);
  assign rsp_err   = err_q;
`else
  assign mem_oe    = (state_q == S_RD);
  assign rsp_err   = 1'b0;
`endif
  assign mem_addr  = addr_q;
  assign mem_data  = (state_q == S_WR) ? wdata_q : {DATA_W{1'bz}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed checks of two sram_ctrl instances (RD_WAIT 0 and 3), each on a
// registered-output SRAM model; honours SRAM_CTRL_VERIFY_EN for the expected write timing.

module tb_sram_ctrl;

`ifdef SRAM_CTRL_VERIFY_EN
  localparam bit Vfy = 1'b1;
`else
  localparam bit Vfy = 1'b0;
`endif
  localparam int WrLatA = Vfy ? 4 : 2;
  localparam int WrLatB = Vfy ? 7 : 2;
  localparam int WrOeA  = Vfy ? 2 : 0;

  logic clk, rst;
  int   nCompared, nMismatched;

  logic        aValid, aReady, aWe, aRspValid, aErr, aBusy, aMemWe, aMemOe, corruptA;
  logic [17:0] aAddr, aMemAddr;
  logic [15:0] aWdata, aRdata, doutA;
  wire  [15:0] aMemData;
  logic [15:0] ramA [0:262143];

  logic        bValid, bReady, bWe, bRspValid, bErr, bBusy, bMemWe, bMemOe;
  logic [17:0] bAddr, bMemAddr;
  logic [15:0] bWdata, bRdata, doutB;
  wire  [15:0] bMemData;
  logic [15:0] ramB [0:262143];

  sram_ctrl #(.ADDR_W(18), .DATA_W(16), .RD_WAIT(0)) dutA (
    .clk(clk), .rst(rst), .req_valid(aValid), .req_ready(aReady), .req_we(aWe),
    .req_addr(aAddr), .req_wdata(aWdata), .rsp_valid(aRspValid), .rsp_rdata(aRdata),
    .rsp_err(aErr), .busy(aBusy), .mem_we(aMemWe), .mem_oe(aMemOe),
    .mem_addr(aMemAddr), .mem_data(aMemData)
  );

  sram_ctrl #(.ADDR_W(18), .DATA_W(16), .RD_WAIT(3)) dutB (
    .clk(clk), .rst(rst), .req_valid(bValid), .req_ready(bReady), .req_we(bWe),
    .req_addr(bAddr), .req_wdata(bWdata), .rsp_valid(bRspValid), .rsp_rdata(bRdata),
    .rsp_err(bErr), .busy(bBusy), .mem_we(bMemWe), .mem_oe(bMemOe),
    .mem_addr(bMemAddr), .mem_data(bMemData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: write on the closing edge of mem_we, output registered every edge.
  always @(posedge clk) begin
    if (aMemWe) ramA[aMemAddr] <= aMemData;
    doutA <= ramA[aMemAddr];
    if (bMemWe) ramB[bMemAddr] <= bMemData;
    doutB <= ramB[bMemAddr];
  end
  // corruptA models a stuck-at-0 on data bit 0 during readback.
  assign aMemData = aMemOe ? (doutA & ~{15'b0, corruptA}) : 16'bz;
  assign bMemData = bMemOe ? doutB : 16'bz;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput("A we&oe exclusive", 32'(aMemWe & aMemOe), 32'd0);
    checkOutput("A ready while busy", 32'(aReady & aBusy), 32'd0);
    checkOutput("B we&oe exclusive", 32'(bMemWe & bMemOe), 32'd0);
    checkOutput("B ready while busy", 32'(bReady & bBusy), 32'd0);
    if (aMemOe) checkOutput("A bus only SRAM", 32'(aMemData), 32'(doutA & ~{15'b0, corruptA}));
    if (bMemOe) checkOutput("B bus only SRAM", 32'(bMemData), 32'(doutB));
  endtask

  task automatic applyStimulus(input bit sel, input logic we, input logic [17:0] addr,
                               input logic [15:0] wd, output int lat, output int oeCnt,
                               output logic [15:0] rd, output logic err);
    int n;
    if (sel) begin bWe = we; bAddr = addr; bWdata = wd; bValid = 1'b1; end
    else     begin aWe = we; aAddr = addr; aWdata = wd; aValid = 1'b1; end
    n = 0;
    while (!(sel ? bReady : aReady) && n < 20) begin tick(); n++; end
    checkOutput("ready before accept", 32'(sel ? bReady : aReady), 32'd1);
    tick();
    // Inputs are don't-care once accepted; scramble them.
    if (sel) begin bValid = 1'b0; bWe = 1'($urandom); bAddr = 18'($urandom); bWdata = 16'($urandom); end
    else     begin aValid = 1'b0; aWe = 1'($urandom); aAddr = 18'($urandom); aWdata = 16'($urandom); end
    oeCnt = (sel ? bMemOe : aMemOe) ? 1 : 0;
    lat = 0;
    while (!(sel ? bRspValid : aRspValid) && lat < 40) begin
      tick();
      lat++;
      if (sel ? bMemOe : aMemOe) oeCnt++;
    end
    rd  = sel ? bRdata : aRdata;
    err = sel ? bErr : aErr;
  endtask

  initial begin
    int lat, oeCnt, n, k, nRsp;
    logic [15:0] rd, expRd;
    logic err, rdy, lastRead;

    nCompared = 0; nMismatched = 0;
    rst = 1'b1; corruptA = 1'b0;
    aValid = 0; aWe = 0; aAddr = '0; aWdata = '0;
    bValid = 0; bWe = 0; bAddr = '0; bWdata = '0;

    #2;
    checkOutput("rst mem_we", 32'(aMemWe), 32'd0);
    checkOutput("rst mem_oe", 32'(aMemOe), 32'd0);
    checkOutput("rst mem_addr", 32'(aMemAddr), 32'd0);
    checkOutput("rst rsp_valid", 32'(aRspValid), 32'd0);
    checkOutput("rst rsp_rdata", 32'(aRdata), 32'd0);
    checkOutput("rst rsp_err", 32'(aErr), 32'd0);
    checkOutput("rst busy", 32'(aBusy), 32'd0);
    checkOutput("rst req_ready", 32'(aReady), 32'd0);
    checkOutput("rst B req_ready", 32'(bReady), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("ready after rst", 32'(aReady), 32'd1);

    $display("[TB] basic write/read");
    applyStimulus(0, 1'b1, 18'h00005, 16'hBEEF, lat, oeCnt, rd, err);
    checkOutput("wr BEEF latency", 32'(lat), 32'(WrLatA));
    checkOutput("wr BEEF oe cycles", 32'(oeCnt), 32'(WrOeA));
    checkOutput("wr BEEF err", 32'(err), 32'd0);
    checkOutput("wr BEEF rdata", 32'(rd), Vfy ? 32'hBEEF : 32'h0);
    applyStimulus(0, 1'b0, 18'h00005, 16'h0000, lat, oeCnt, rd, err);
    checkOutput("rd 5 latency", 32'(lat), 32'd2);
    checkOutput("rd 5 oe cycles", 32'(oeCnt), 32'd2);
    checkOutput("rd 5 rdata", 32'(rd), 32'hBEEF);
    checkOutput("rd 5 err", 32'(err), 32'd0);

    $display("[TB] address extremes");
    applyStimulus(0, 1'b1, 18'h3FFFF, 16'h1234, lat, oeCnt, rd, err);
    checkOutput("wr top latency", 32'(lat), 32'(WrLatA));
    checkOutput("wr top rdata", 32'(rd), Vfy ? 32'h1234 : 32'hBEEF);
    applyStimulus(0, 1'b1, 18'h00000, 16'h5678, lat, oeCnt, rd, err);
    checkOutput("wr zero rdata", 32'(rd), Vfy ? 32'h5678 : 32'hBEEF);
    applyStimulus(0, 1'b0, 18'h3FFFF, 16'h0000, lat, oeCnt, rd, err);
    checkOutput("rd top rdata", 32'(rd), 32'h1234);
    applyStimulus(0, 1'b0, 18'h00000, 16'h0000, lat, oeCnt, rd, err);
    checkOutput("rd zero rdata", 32'(rd), 32'h5678);

    $display("[TB] back-to-back alternating stream");
    k = 0; nRsp = 0; lastRead = 1'b0; expRd = '0;
    aWe = 1'b1; aAddr = 18'h100; aWdata = 16'hC000; aValid = 1'b1;
    for (int c = 0; c < 200 && nRsp < 8; c++) begin
      rdy = aReady;
      tick();
      if (aRspValid) begin
        nRsp++;
        if (lastRead) checkOutput("stream rdata", 32'(aRdata), 32'(expRd));
      end
      if (rdy && k < 8) begin
        lastRead = !aWe;
        expRd = 16'hC000 + 16'(k / 2);
        k++;
        if (k < 8) begin
          aWe = (k % 2 == 0);
          aAddr = 18'h100 + 18'(k / 2);
          aWdata = 16'hC000 + 16'(k / 2);
        end else begin
          aValid = 1'b0;
        end
      end
    end
    checkOutput("stream responses", 32'(nRsp), 32'd8);

    $display("[TB] reset during write");
    aWe = 1'b1; aAddr = 18'h00005; aWdata = 16'h7777; aValid = 1'b1;
    n = 0;
    while (!aReady && n < 20) begin tick(); n++; end
    tick();
    aValid = 1'b0;
    checkOutput("abort in WR", 32'(aMemWe), 32'd1);
    #3 rst = 1'b1;
    #1;
    checkOutput("abort we drop", 32'(aMemWe), 32'd0);
    checkOutput("abort busy drop", 32'(aBusy), 32'd0);
    checkOutput("abort ready low", 32'(aReady), 32'd0);
    tick();
    checkOutput("abort no rsp", 32'(aRspValid), 32'd0);
    #2 rst = 1'b0;
    tick();
    checkOutput("abort no late rsp", 32'(aRspValid), 32'd0);
    applyStimulus(0, 1'b0, 18'h00005, 16'h0000, lat, oeCnt, rd, err);
    checkOutput("abort old contents", 32'(rd), 32'hBEEF);
    checkOutput("abort rd latency", 32'(lat), 32'd2);

    $display("[TB] verify compare");
    corruptA = 1'b1;
    applyStimulus(0, 1'b1, 18'h00022, 16'h0001, lat, oeCnt, rd, err);
    corruptA = 1'b0;
    checkOutput("vfy forced err", 32'(err), Vfy ? 32'd1 : 32'd0);
    checkOutput("vfy forced rdata", 32'(rd), Vfy ? 32'h0000 : 32'hBEEF);
    applyStimulus(0, 1'b1, 18'h00023, 16'h0001, lat, oeCnt, rd, err);
    checkOutput("vfy clean err", 32'(err), 32'd0);
    checkOutput("vfy clean rdata", 32'(rd), Vfy ? 32'h0001 : 32'hBEEF);

    $display("[TB] RD_WAIT=3 instance");
    applyStimulus(1, 1'b1, 18'h00155, 16'hA5A5, lat, oeCnt, rd, err);
    checkOutput("B wr latency", 32'(lat), 32'(WrLatB));
    checkOutput("B wr err", 32'(err), 32'd0);
    applyStimulus(1, 1'b0, 18'h00155, 16'h0000, lat, oeCnt, rd, err);
    checkOutput("B rd latency", 32'(lat), 32'd5);
    checkOutput("B rd oe cycles", 32'(oeCnt), 32'd5);
    checkOutput("B rd rdata", 32'(rd), 32'hA5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Bus initiator for the external 256K x 16 asynchronous-style SRAM port (we/oe/18-bit addr/16-bit bidirectional data) modelled by `ram_16bit`. It converts single-word requests from the core (fetch and load/store paths, arbitrated upstream) into correctly sequenced SRAM bus cycles. It owns the tristate data bus and guarantees that `mem_we` and `mem_oe` are never asserted together. It returns read data and write acknowledgements through a one-cycle response pulse.

## Interface
- `ADDR_W`, 18, SRAM word-address width.
- `DATA_W`, 16, SRAM data width.
- `RD_WAIT`, 0, extra wait cycles inserted before read capture; legal range 0..7.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; high only in IDLE while `rst` is low.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  DATA_W  read data; holds its value until the next capture.
- `rsp_err`  out  1  verify mismatch, qualified by `rsp_valid`; constant 0 unless `SRAM_CTRL_VERIFY_EN` is defined.
- `busy`  out  1  state is not IDLE.
- `mem_we`  out  1  SRAM write enable.
- `mem_oe`  out  1  SRAM output enable.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_data`  inout  DATA_W  SRAM data; driven only in WR, otherwise high-Z.

## Operation
- The request is accepted on a rising edge where `req_valid && req_ready`. The controller latches `req_we`, `req_addr` and `req_wdata` internally; the inputs are don't-care afterwards.
- States:
  - IDLE: `mem_we`=0, `mem_oe`=0, data bus Z.
  - RD: `mem_oe`=1, `mem_addr` = latched address. Lasts `RD_WAIT`+2 cycles.
    - The SRAM registers its output on the first edge in RD.
    - The controller samples `mem_data` into `rsp_rdata` on the last edge of RD, then goes to IDLE with `rsp_valid`=1 for one cycle.
  - WR: `mem_we`=1, `mem_oe`=0, `mem_data` = latched wdata, `mem_addr` = latched address. Lasts 1 cycle; the SRAM writes on its closing edge.
  - WR_REC: `mem_we`=0, bus Z, address held. Lasts 1 cycle.
    - Without verify: `rsp_valid`=1 in this cycle, then IDLE.
    - With verify: go to VFY.
  - VFY (verify build only): identical sequencing to RD.
    - On capture, `rsp_rdata` = readback and `rsp_err` = (readback != latched wdata).
    - `rsp_valid`=1 for one cycle, then IDLE.
- Write acknowledgements leave `rsp_rdata` unchanged (non-verify build).
- `mem_we && mem_oe` is never 1. `mem_data` is never driven while `mem_oe`=1. WR_REC guarantees one undriven cycle between a write and the next read's `mem_oe`.
- Addresses are used unmodified; there is no wrap or range check, and 0x3FFFF is a legal address.
- A new request can be accepted in the same cycle that `rsp_valid` is high (state is IDLE).

## Timing
- Reset values: `mem_we`=0, `mem_oe`=0, `mem_addr`=0, `mem_data`=Z, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0, `req_ready`=0 while `rst` is high, state IDLE.
- Reset is asynchronous: asserting `rst` mid-operation drops `mem_we`/`mem_oe` and releases the bus immediately.
  - The aborted request produces no `rsp_valid`.
  - A write aborted before its closing edge is not committed.
- Read latency: `rsp_valid` rises `RD_WAIT`+2 cycles after the acceptance edge. Occupancy is `RD_WAIT`+3 cycles including IDLE.
- Write latency: `rsp_valid` rises 2 cycles after acceptance (occupancy 3). With verify: `RD_WAIT`+4 cycles (occupancy `RD_WAIT`+5).
- `req_ready` = (state == IDLE) && !`rst`, combinational.
- All other outputs are registered or decoded from state only; no combinational path from `req_*` to `mem_*`.

## Configuration
- `SRAM_CTRL_VERIFY_EN` defined:
  - Every write is followed by WR_REC and then a VFY readback of the same address.
  - `rsp_valid` is deferred until the compare completes; `rsp_err` reports a mismatch and `rsp_rdata` carries the readback.
- `SRAM_CTRL_VERIFY_EN` not defined:
  - The VFY state and comparator are absent and `rsp_err` is tied 0.
  - The write acknowledgement is given in WR_REC.

## Test plan
- Write 0xBEEF to 0x00005, then read 0x00005 (`RD_WAIT`=0) -> write `rsp_valid` 2 cycles after acceptance; read `rsp_valid` 2 cycles after acceptance with `rsp_rdata`=0xBEEF.
- Write 0x1234 to 0x3FFFF and 0x5678 to 0x00000, read both -> 0x1234 and 0x5678; no aliasing.
- `req_valid` held high with alternating write/read streams, checked every cycle -> `mem_we && mem_oe` never 1; `mem_data` never driven while `mem_oe`=1; `req_ready` low whenever `busy`=1.
- `RD_WAIT`=3, read of preloaded 0xA5A5 -> `rsp_valid` exactly 5 cycles after acceptance with 0xA5A5; `mem_oe` high for 5 cycles.
- Assert `rst` mid-WR, before the closing edge -> `mem_we` falls immediately, no `rsp_valid`, and a later read returns the old contents.
- `SRAM_CTRL_VERIFY_EN` defined, bench forces `mem_data[0]` to 0 during VFY, write 0x0001 -> `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0x0000. Without the force -> `rsp_err`=0.
